uart_tx: RTL

- 8N1 UART transmitter, the transmit-side partner of the existing uart_rx.
- Accepts a byte over a valid/ready handshake and serialises it LSB-first on tx at BAUD_TICKS clocks per bit.
- A one-entry holding register lets a second byte queue during a frame, so back-to-back frames have no idle gap.
- Sits between the fabric/CPU side and the board TX pin. Its clock and baud defaults match uart_rx so the two loop back directly.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the transmitter state encoding.
// Used by uart_tx, uart_baud_tick and the receive side.
package uart_pkg;

  localparam int BAUD_TICKS_DEFAULT = 5208;
  localparam int CNT_W_DEFAULT      = 13;
  localparam int DATA_BITS          = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: reloads BAUD_TICKS-1 and emits a one-cycle tick at zero.
// restart holds the counter at BAUD_TICKS-1 so the next period is full length; no backpressure.
module uart_baud_tick #(
  parameter int BAUD_TICKS = 5208,
  parameter int CNT_W      = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_TICKS - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q - ONE;
    if (restart || (cnt_q == '0)) begin
      cnt_d = RELOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !restart && (cnt_q == '0);
  assign cnt  = cnt_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register; UART_TX_PARITY_EN adds an even parity bit (8E1).
// tx falls two edges after an accept from idle; ready drops while the holding register is full.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_TICKS = BAUD_TICKS_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] txbyte,
  input  logic       send,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  tx_state_t  state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       load;
  logic       accept;
  logic       tick;
  logic [CNT_W-1:0] cnt;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  uart_baud_tick #(
    .BAUD_TICKS(BAUD_TICKS),
    .CNT_W     (CNT_W)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(state_q == IDLE),
    .tick   (tick),
    .cnt    (cnt)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    load       = 1'b0;
    accept     = send && !hold_vld_q;

    if (accept) begin
      hold_d     = txbyte;
      hold_vld_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_vld_q) load = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (hold_vld_q) load = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reload never collides with an accept: ready is low whenever hold_vld_q is set.
    if (load) begin
      state_d    = START;
      shift_d    = hold_q;
      hold_vld_d = 1'b0;
    end

`ifdef UART_TX_PARITY_EN
    par_d = load ? ^hold_q : par_q;
`endif

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    // Registered, so raise it one cycle ahead of the stop bit's final cycle.
    done_d = (state_q == STOP) && (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign ready = !hold_vld_q;
  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
